// File: rtl/song_player_seq.sv
// Auto-play song sequencer: walks one song of an external note library entry by
// entry and drives registered buzzer note/octave and one-hot LED outputs.
module song_player_seq #(
  parameter int         NUM_SONGS      = 3,
  parameter int         SONG_LEN       = 56,
  parameter int         TICKS_PER_UNIT = 10000000,
  parameter int         GAP_TICKS      = 0,
  parameter logic [3:0] END_NOTE       = 4'hF,
  localparam int        SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int        PW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          next_song,
  input  logic          prev_song,
  input  logic          pause,
  input  logic          loop_en,
  output logic [SW-1:0] lib_song,
  output logic [PW-1:0] lib_pos,
  input  logic [3:0]    lib_note,
  input  logic [1:0]    lib_oct,
  input  logic [3:0]    lib_dur,
  output logic [3:0]    note_to_play,
  output logic [1:0]    octave_out,
  output logic [6:0]    led_out,
  output logic          playing
);

  // One counter serves both the note duration and the gap, so it is sized
  // for whichever of the two can be longer.
  localparam int MAX_TICKS = (15 * TICKS_PER_UNIT > GAP_TICKS) ? 15 * TICKS_PER_UNIT : GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int GAP_LAST  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam logic [CW-1:0] TPU = CW'(TICKS_PER_UNIT);

  typedef enum logic [2:0] {FETCH_A, FETCH_D, PLAY, GAP, DONE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] song, song_n;
  logic [PW-1:0] pos, pos_n;
  logic [CW-1:0] cnt, cnt_n, target, target_n;
  logic [3:0]    note, note_n;
  logic [1:0]    oct, oct_n;
  logic          next_q, prev_q;
  logic          next_rise, prev_rise;
  logic          adv, eos, audible;
  logic [3:0]    dur_eff;
  logic [6:0]    led_n;

  assign next_rise = next_song & ~next_q;
  assign prev_rise = prev_song & ~prev_q;
  assign lib_song  = song;
  assign lib_pos   = pos;

  // Next-state logic: song change overrides everything, then the playback FSM;
  // advance and end-of-song are resolved after the case so they are written once.
  always_comb begin
    state_n  = state;
    song_n   = song;
    pos_n    = pos;
    cnt_n    = cnt;
    target_n = target;
    note_n   = note;
    oct_n    = oct;
    adv      = 1'b0;
    eos      = 1'b0;
    audible  = 1'b0;
    led_n    = '0;
    dur_eff  = (lib_dur == 4'd0) ? 4'd1 : lib_dur;
    if (next_rise) begin
      song_n  = (song == SW'(NUM_SONGS - 1)) ? '0 : song + SW'(1);
      pos_n   = '0;
      cnt_n   = '0;
      state_n = FETCH_A;
    end else if (prev_rise) begin
      song_n  = (song == '0) ? SW'(NUM_SONGS - 1) : song - SW'(1);
      pos_n   = '0;
      cnt_n   = '0;
      state_n = FETCH_A;
    end else begin
      case (state)
        FETCH_A: state_n = FETCH_D;
        FETCH_D: begin
          note_n   = lib_note;
          oct_n    = lib_oct;
          target_n = CW'(dur_eff) * TPU;
          cnt_n    = '0;
          if (lib_note == END_NOTE) eos = 1'b1;
          else                      state_n = PLAY;
        end
        PLAY: if (!pause) begin
          if (cnt == target - CW'(1)) begin
            cnt_n = '0;
            if (GAP_TICKS > 0) state_n = GAP;
            else               adv = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GAP: if (!pause) begin
          if (cnt == CW'(GAP_LAST)) begin
            cnt_n = '0;
            adv   = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        DONE:    state_n = DONE;
        default: state_n = FETCH_A;
      endcase
      if (adv) begin
        if (pos == PW'(SONG_LEN - 1)) begin
          eos = 1'b1;
        end else begin
          pos_n   = pos + PW'(1);
          state_n = FETCH_A;
        end
      end
      if (eos) begin
        if (loop_en) begin
          pos_n   = '0;
          state_n = FETCH_A;
        end else begin
          state_n = DONE;
        end
      end
    end
    // Outputs are registered from the next state, so a pause is heard as rest
    // on the same edge that freezes the counter.
    audible = (state_n == PLAY) && !pause;
    if (audible && note_n >= 4'd1 && note_n <= 4'd7) led_n = 7'd1 << (note_n - 4'd1);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH_A;
      song         <= '0;
      pos          <= '0;
      cnt          <= '0;
      target       <= '0;
      note         <= '0;
      oct          <= '0;
      next_q       <= 1'b0;
      prev_q       <= 1'b0;
      note_to_play <= '0;
      octave_out   <= '0;
      led_out      <= '0;
      playing      <= 1'b0;
    end else begin
      state        <= state_n;
      song         <= song_n;
      pos          <= pos_n;
      cnt          <= cnt_n;
      target       <= target_n;
      note         <= note_n;
      oct          <= oct_n;
      next_q       <= next_song;
      prev_q       <= prev_song;
      note_to_play <= audible ? note_n : 4'd0;
      led_out      <= led_n;
      if (state_n == PLAY) octave_out <= oct_n;
      playing      <= (state_n != DONE) && !(pause && (state_n == PLAY || state_n == GAP));
    end
  end

endmodule

// File: tb/tb_song_player_seq.sv
// Bench for song_player_seq: a registered note library plus a trace model that
// expands each song into the expected per-cycle output sequence.
module tb_song_player_seq;
  localparam int         NS   = 3;
  localparam int         SL   = 4;
  localparam int         TPU  = 4;
  localparam int         GAPT = 2;
  localparam logic [3:0] ENDN = 4'hF;

  logic       clk = 1'b0, reset = 1'b1;
  logic       next_song = 1'b0, prev_song = 1'b0, pause = 1'b0, loop_en = 1'b1;
  logic [1:0] lib_song, lib_pos;
  logic [3:0] lib_note = '0;
  logic [1:0] lib_oct = '0;
  logic [3:0] lib_dur = '0;
  logic [3:0] note_to_play;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic       playing;

  logic [3:0] mn[4][4];
  logic [1:0] mo[4][4];
  logic [3:0] md[4][4];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] oct;
    logic [6:0] led;
    logic       play;
    logic       chk_oct;
  } exp_t;

  song_player_seq #(
    .NUM_SONGS(NS), .SONG_LEN(SL), .TICKS_PER_UNIT(TPU), .GAP_TICKS(GAPT), .END_NOTE(ENDN)
  ) dut (
    .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song),
    .pause(pause), .loop_en(loop_en), .lib_song(lib_song), .lib_pos(lib_pos),
    .lib_note(lib_note), .lib_oct(lib_oct), .lib_dur(lib_dur),
    .note_to_play(note_to_play), .octave_out(octave_out), .led_out(led_out),
    .playing(playing)
  );

  always #5 clk = ~clk;

  // Library: data for the presented address appears one cycle later.
  always @(posedge clk) begin
    lib_note <= mn[lib_song][lib_pos];
    lib_oct  <= mo[lib_song][lib_pos];
    lib_dur  <= md[lib_song][lib_pos];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] led_of(input logic [3:0] n);
    case (n)
      4'd1: return 7'b0000001;
      4'd2: return 7'b0000010;
      4'd3: return 7'b0000100;
      4'd4: return 7'b0001000;
      4'd5: return 7'b0010000;
      4'd6: return 7'b0100000;
      4'd7: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic set_plan_song0();
    mn[0][0] = 4'd1; mo[0][0] = 2'd0; md[0][0] = 4'd1;
    mn[0][1] = 4'd3; mo[0][1] = 2'd1; md[0][1] = 4'd2;
    mn[0][2] = 4'd7; mo[0][2] = 2'd2; md[0][2] = 4'd1;
    mn[0][3] = 4'd5; mo[0][3] = 2'd0; md[0][3] = 4'd0;
  endtask

  task automatic rand_song(input int s);
    for (int p = 0; p < SL; p++) begin
      mn[s][p] = 4'($urandom_range(0, 14));
      mo[s][p] = 2'($urandom_range(0, 3));
      md[s][p] = 4'($urandom_range(0, 3));
    end
  endtask

  // One-cycle pulse on next/prev; returns at the sample point of the first
  // FETCH_A cycle of the newly selected song.
  task automatic change(input logic nx, input logic pv);
    @(negedge clk);
    next_song = nx;
    prev_song = pv;
    @(negedge clk);
    next_song = 1'b0;
    prev_song = 1'b0;
  endtask

  // Expand song s into its expected output trace: each entry costs two quiet
  // fetch cycles, then dur*TPU note cycles and GAPT quiet cycles; an end marker
  // or the last slot restarts or stops the song. Compare n cycles starting now.
  task automatic trace(input int s, input bit lp, input int n, input bit from_reset, input string tag);
    exp_t q[$];
    exp_t e;
    int   p = 0;
    int   d;
    bit   done = 1'b0;
    while (q.size() < n) begin
      if (done) begin
        e = '0;
        q.push_back(e);
        continue;
      end
      e = '0;
      e.play = 1'b1;
      q.push_back(e);
      q.push_back(e);
      if (mn[s][p] == ENDN) begin
        if (lp) p = 0;
        else    done = 1'b1;
      end else begin
        d = (md[s][p] == 4'd0) ? 1 : int'(md[s][p]);
        e.note    = mn[s][p];
        e.oct     = mo[s][p];
        e.led     = led_of(mn[s][p]);
        e.play    = 1'b1;
        e.chk_oct = 1'b1;
        repeat (d * TPU) q.push_back(e);
        e = '0;
        e.play = 1'b1;
        repeat (GAPT) q.push_back(e);
        if (p == SL - 1) begin
          if (lp) p = 0;
          else    done = 1'b1;
        end else begin
          p++;
        end
      end
    end
    if (from_reset) q[0].play = 1'b0;
    chk({tag, ":lib_song"}, 32'(lib_song), 32'(s));
    chk({tag, ":lib_pos"}, 32'(lib_pos), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      e = q[i];
      chk($sformatf("%s[%0d]", tag, i), 32'({note_to_play, led_out, playing}), 32'({e.note, e.led, e.play}));
      if (e.chk_oct) chk($sformatf("%s[%0d]:oct", tag, i), 32'(octave_out), 32'(e.oct));
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 4; p++) begin
        mn[s][p] = '0; mo[s][p] = '0; md[s][p] = '0;
      end
    set_plan_song0();
    rand_song(1);
    rand_song(2);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 32'({note_to_play, octave_out, led_out, playing, lib_song, lib_pos}), 32'd0);

    // Directed song 0, looping
    @(negedge clk);
    reset = 1'b0;
    trace(0, 1'b1, 80, 1'b1, "loop0");

    // next and prev together from song 0: next wins
    change(1'b1, 1'b1);
    trace(1, 1'b1, 100, 1'b0, "rand1");

    // prev 1 -> 0 with an end marker at entry 2, one-shot
    mn[0][2] = ENDN;
    loop_en  = 1'b0;
    change(1'b0, 1'b1);
    trace(0, 1'b0, 150, 1'b0, "end0");

    // prev wraps 0 -> 2, one-shot through the last slot
    change(1'b0, 1'b1);
    trace(2, 1'b0, 120, 1'b0, "rand2");

    // next wraps 2 -> 0; pause mid-note
    set_plan_song0();
    loop_en = 1'b1;
    change(1'b1, 1'b0);
    chk("p_song", 32'(lib_song), 32'd0);
    chk("p_fetch0", 32'({note_to_play, playing}), 32'({4'd0, 1'b1}));
    @(negedge clk);
    chk("p_fetch1", 32'({note_to_play, playing}), 32'({4'd0, 1'b1}));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("p_pre%0d", i), 32'({note_to_play, led_out, playing}), 32'({4'd1, 7'b0000001, 1'b1}));
    end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("p_hold%0d", i), 32'({note_to_play, led_out, playing}), 32'd0);
    end
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("p_post%0d", i), 32'({note_to_play, led_out, playing}), 32'({4'd1, 7'b0000001, 1'b1}));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("p_quiet%0d", i), 32'({note_to_play, led_out, playing}), 32'({4'd0, 7'd0, 1'b1}));
    end
    @(negedge clk);
    chk("p_next_note", 32'({note_to_play, octave_out, led_out}), 32'({4'd3, 2'd1, 7'b0000100}));

    // Asynchronous reset between clock edges mid-note
    #2 reset = 1'b1;
    #1 chk("async_rst", 32'({note_to_play, octave_out, led_out, playing, lib_song, lib_pos}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    trace(0, 1'b1, 60, 1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
